microcode_sequencer: RTL and testbench

MICROCODE_SEQUENCER -- requirements
Module: microcode_sequencer

---
 rtl/microcode_sequencer_pkg.sv | 59 +++++
 rtl/microcode_sequencer_decode.sv | 28 ++
 rtl/microcode_sequencer.sv | 155 +++++++++++++++
 tb/tb_microcode_sequencer.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/microcode_sequencer_pkg.sv
// Shared types and constants for the microcode sequencer: FSM states,
// instruction classes, microcode entry addresses and micro-PC step codes.
package microcode_sequencer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_EXEC,
    ST_MEM,
    ST_WB,
    ST_HALT
  } state_e;

  typedef enum logic [2:0] {
    CLS_NOP,
    CLS_ALU,
    CLS_LOAD,
    CLS_STORE,
    CLS_BRANCH,
    CLS_JUMP,
    CLS_ILLEGAL
  } uclass_e;

  localparam int MEM_TIMEOUT_DEFAULT = 15;

  localparam logic [1:0] STEP_IDLE = 2'd0;
  localparam logic [1:0] STEP_EXEC = 2'd1;
  localparam logic [1:0] STEP_MEM  = 2'd2;
  localparam logic [1:0] STEP_WB   = 2'd3;

  localparam logic [5:0] UA_NOP     = 6'd0;
  localparam logic [5:0] UA_ADD     = 6'd1;
  localparam logic [5:0] UA_SUB     = 6'd2;
  localparam logic [5:0] UA_AND     = 6'd3;
  localparam logic [5:0] UA_OR      = 6'd4;
  localparam logic [5:0] UA_XOR     = 6'd5;
  localparam logic [5:0] UA_SLL     = 6'd6;
  localparam logic [5:0] UA_SRL     = 6'd7;
  localparam logic [5:0] UA_SRA     = 6'd8;
  localparam logic [5:0] UA_SLT     = 6'd9;
  localparam logic [5:0] UA_SLTU    = 6'd10;
  localparam logic [5:0] UA_LOAD    = 6'd11;
  localparam logic [5:0] UA_STORE   = 6'd12;
  localparam logic [5:0] UA_BRANCH  = 6'd13;
  localparam logic [5:0] UA_ADDI    = 6'd14;
  localparam logic [5:0] UA_ANDI    = 6'd15;
  localparam logic [5:0] UA_ORI     = 6'd16;
  localparam logic [5:0] UA_XORI    = 6'd17;
  localparam logic [5:0] UA_SLLI    = 6'd18;
  localparam logic [5:0] UA_SRLI    = 6'd19;
  localparam logic [5:0] UA_SRAI    = 6'd20;
  localparam logic [5:0] UA_SLTI    = 6'd21;
  localparam logic [5:0] UA_SLTIU   = 6'd22;
  localparam logic [5:0] UA_LUI     = 6'd23;
  localparam logic [5:0] UA_AUIPC   = 6'd24;
  localparam logic [5:0] UA_JAL     = 6'd25;
  localparam logic [5:0] UA_JALR    = 6'd26;
  localparam logic [5:0] UA_ILLEGAL = 6'd63;

endpackage

// File: rtl/microcode_sequencer_decode.sv
// Combinational classifier: maps a 6-bit microcode entry address to the
// instruction class that drives the sequencer FSM.
module micro_class_decode
  import microcode_sequencer_pkg::*;
(
  input  logic [5:0] addr_i,
  output uclass_e    cls_o
);

  always_comb begin
    cls_o = CLS_ILLEGAL;
    if (addr_i == UA_NOP) begin
      cls_o = CLS_NOP;
    end else if (addr_i == UA_LOAD) begin
      cls_o = CLS_LOAD;
    end else if (addr_i == UA_STORE) begin
      cls_o = CLS_STORE;
    end else if (addr_i == UA_BRANCH) begin
      cls_o = CLS_BRANCH;
    end else if (addr_i == UA_JAL || addr_i == UA_JALR) begin
      cls_o = CLS_JUMP;
    end else if (addr_i < UA_JAL) begin
      // Remaining legal addresses: 1-10 and 14-24
      cls_o = CLS_ALU;
    end
  end

endmodule

// File: rtl/microcode_sequencer.sv
// Microcode sequencer: IDLE -> EXEC -> [MEM] -> WB per instruction, with
// sticky HALT on illegal entry addresses or memory timeout.
module microcode_sequencer
  import microcode_sequencer_pkg::*;
#(
  parameter int MEM_TIMEOUT = MEM_TIMEOUT_DEFAULT,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             instr_valid,
  input  logic [5:0]       mapped_address,
  input  logic             branch_taken,
  input  logic             mem_ready,
  output logic             instr_ready,
  output logic [7:0]       upc,
  output logic             alu_en,
  output logic             mem_req,
  output logic             mem_we,
  output logic             rf_we,
  output logic             pc_inc,
  output logic             pc_load,
  output logic             illegal,
  output logic             mem_fault,
  output logic             halted,
  output logic [CNT_W-1:0] retired
);

  localparam int TMO_W = $clog2(MEM_TIMEOUT + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(MEM_TIMEOUT - 1);

  state_e           state_q, state_d;
  logic [5:0]       addr_q, addr_d;
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic [CNT_W-1:0] retired_q, retired_d;
  logic             illegal_q, illegal_d;
  logic             fault_q, fault_d;
  uclass_e          in_cls, cur_cls;

  micro_class_decode u_in_decode (
    .addr_i (mapped_address),
    .cls_o  (in_cls)
  );

  micro_class_decode u_cur_decode (
    .addr_i (addr_q),
    .cls_o  (cur_cls)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      addr_q    <= '0;
      tmo_q     <= '0;
      retired_q <= '0;
      illegal_q <= 1'b0;
      fault_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      tmo_q     <= tmo_d;
      retired_q <= retired_d;
      illegal_q <= illegal_d;
      fault_q   <= fault_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    tmo_d       = tmo_q;
    retired_d   = retired_q;
    illegal_d   = illegal_q;
    fault_d     = fault_q;
    instr_ready = 1'b0;
    alu_en      = 1'b0;
    mem_req     = 1'b0;
    mem_we      = 1'b0;
    rf_we       = 1'b0;
    pc_inc      = 1'b0;
    pc_load     = 1'b0;
    halted      = 1'b0;
    upc         = {addr_q, STEP_IDLE};

    case (state_q)
      ST_IDLE: begin
        instr_ready = 1'b1;
        if (instr_valid) begin
          addr_d = mapped_address;
          if (in_cls == CLS_ILLEGAL) begin
            state_d   = ST_HALT;
            illegal_d = 1'b1;
          end else begin
            state_d = ST_EXEC;
          end
        end
      end
      ST_EXEC: begin
        alu_en = 1'b1;
        upc    = {addr_q, STEP_EXEC};
        if (cur_cls == CLS_LOAD || cur_cls == CLS_STORE) begin
          state_d = ST_MEM;
          tmo_d   = '0;
        end else begin
          state_d = ST_WB;
        end
      end
      ST_MEM: begin
        mem_req = 1'b1;
        mem_we  = (cur_cls == CLS_STORE);
        upc     = {addr_q, STEP_MEM};
        // A completion in the final allowed cycle still wins over the timeout
        if (mem_ready) begin
          state_d = ST_WB;
        end else if (tmo_q == TMO_LAST) begin
          state_d = ST_HALT;
          fault_d = 1'b1;
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
        end
      end
      ST_WB: begin
        upc       = {addr_q, STEP_WB};
        retired_d = retired_q + CNT_W'(1);
        state_d   = ST_IDLE;
        case (cur_cls)
          CLS_NOP, CLS_STORE: pc_inc = 1'b1;
          CLS_ALU, CLS_LOAD: begin
            rf_we  = 1'b1;
            pc_inc = 1'b1;
          end
          CLS_BRANCH: begin
            pc_load = branch_taken;
            pc_inc  = ~branch_taken;
          end
          CLS_JUMP: begin
            rf_we   = 1'b1;
            pc_load = 1'b1;
          end
          default: ;
        endcase
      end
      ST_HALT: begin
        halted = 1'b1;
        upc    = {UA_ILLEGAL, STEP_IDLE};
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign illegal   = illegal_q;
  assign mem_fault = fault_q;
  assign retired   = retired_q;

endmodule

// File: tb/tb_microcode_sequencer.sv
// Self-checking bench: table-driven vectors, hand-written corner sequences and
// randomized instructions checked against a transaction-level reference model.
module tb_microcode_sequencer;

  localparam int CNT_W = 4;
  localparam int TMO   = 15;

  logic             clk = 1'b0;
  logic             reset, instr_valid, branch_taken, mem_ready;
  logic [5:0]       mapped_address;
  logic             instr_ready, alu_en, mem_req, mem_we, rf_we, pc_inc, pc_load;
  logic             illegal, mem_fault, halted;
  logic [7:0]       upc;
  logic [CNT_W-1:0] retired;

  int checks = 0;
  int failures = 0;
  int exp_retired = 0;
  logic [7:0] upc_log [0:63];

  typedef struct {
    int lat, alu, mreq, mwe, rfw, inc, ld, both, halt, ill, flt, ret;
  } trace_t;

  typedef struct {
    int a; int bt; int rdy; int lat; int rfw; int inc; int ld; int mreq; int mwe;
  } vec_t;

  vec_t tbl [10];

  microcode_sequencer #(.MEM_TIMEOUT(TMO), .CNT_W(CNT_W)) dut (
    .clk            (clk),
    .reset          (reset),
    .instr_valid    (instr_valid),
    .mapped_address (mapped_address),
    .branch_taken   (branch_taken),
    .mem_ready      (mem_ready),
    .instr_ready    (instr_ready),
    .upc            (upc),
    .alu_en         (alu_en),
    .mem_req        (mem_req),
    .mem_we         (mem_we),
    .rf_we          (rf_we),
    .pc_inc         (pc_inc),
    .pc_load        (pc_load),
    .illegal        (illegal),
    .mem_fault      (mem_fault),
    .halted         (halted),
    .retired        (retired)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Instruction-level expectation derived from the address map and timing rules
  function automatic trace_t model(input int a, input bit bt, input int rdy_at);
    trace_t e;
    e = '{default: 0};
    if (a > 26) begin
      e.lat = 1; e.halt = 1; e.ill = 1;
      return e;
    end
    e.alu = 1;
    if (a == 11 || a == 12) begin
      if (rdy_at >= 1 && rdy_at <= TMO) begin
        e.mreq = rdy_at;
        e.lat  = 3 + rdy_at;
      end else begin
        e.mreq = TMO;
        e.lat  = TMO + 2;
        e.halt = 1;
        e.flt  = 1;
      end
      if (a == 12) e.mwe = e.mreq;
      if (e.halt != 0) return e;
    end else begin
      e.lat = 3;
    end
    e.ret = 1;
    e.rfw = (a != 0 && a != 12 && a != 13) ? 1 : 0;
    e.ld  = ((a == 13 && bt) || a >= 25) ? 1 : 0;
    e.inc = 1 - e.ld;
    return e;
  endfunction

  // Accepts one instruction and watches it until IDLE returns or HALT is seen
  task automatic do_instr(input int a, input bit bt, input int rdy_at, output trace_t t);
    int wait_c;
    int memc;
    wait_c = 0;
    memc = 0;
    t = '{default: 0};
    while (!instr_ready && wait_c < 8) begin
      @(negedge clk);
      wait_c++;
    end
    check("accept_ready", instr_ready, 1);
    if (!instr_ready) return;
    instr_valid = 1'b1;
    mapped_address = 6'(a);
    branch_taken = bt;
    mem_ready = 1'b0;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      instr_valid = 1'b0;
      upc_log[c] = upc;
      t.alu += int'(alu_en);
      t.mreq += int'(mem_req);
      t.mwe += int'(mem_we);
      t.rfw += int'(rf_we);
      t.inc += int'(pc_inc);
      t.ld += int'(pc_load);
      if (pc_inc && pc_load) t.both++;
      if (halted) begin
        t.halt = 1;
        t.lat = c;
        break;
      end
      if (instr_ready) begin
        t.lat = c;
        break;
      end
      if (mem_req) begin
        memc++;
        mem_ready = (memc == rdy_at);
      end else begin
        mem_ready = 1'b0;
      end
    end
    mem_ready = 1'b0;
  endtask

  task automatic run_and_check(input string tag, input int a, input bit bt, input int rdy_at);
    trace_t t, e;
    e = model(a, bt, rdy_at);
    do_instr(a, bt, rdy_at, t);
    if (e.ret != 0) exp_retired = (exp_retired + 1) % (1 << CNT_W);
    check({tag, ".latency"}, t.lat, e.lat);
    check({tag, ".alu_en"}, t.alu, e.alu);
    check({tag, ".mem_req"}, t.mreq, e.mreq);
    check({tag, ".mem_we"}, t.mwe, e.mwe);
    check({tag, ".rf_we"}, t.rfw, e.rfw);
    check({tag, ".pc_inc"}, t.inc, e.inc);
    check({tag, ".pc_load"}, t.ld, e.ld);
    check({tag, ".pc_both"}, t.both, 0);
    check({tag, ".halted"}, halted, e.halt);
    check({tag, ".illegal"}, illegal, e.ill);
    check({tag, ".mem_fault"}, mem_fault, e.flt);
    check({tag, ".retired"}, retired, exp_retired);
    $display("txn %s addr=%0d bt=%0d rdy=%0d lat=%0d halted=%0d retired=%0d",
             tag, a, bt, rdy_at, t.lat, halted, retired);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    instr_valid = 1'b0;
    mem_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    exp_retired = 0;
  endtask

  initial begin
    trace_t t;
    tbl[0] = '{1, 0, 0, 3, 1, 1, 0, 0, 0};
    tbl[1] = '{0, 0, 0, 3, 0, 1, 0, 0, 0};
    tbl[2] = '{24, 0, 0, 3, 1, 1, 0, 0, 0};
    tbl[3] = '{13, 1, 0, 3, 0, 0, 1, 0, 0};
    tbl[4] = '{13, 0, 0, 3, 0, 1, 0, 0, 0};
    tbl[5] = '{25, 0, 0, 3, 1, 0, 1, 0, 0};
    tbl[6] = '{26, 1, 0, 3, 1, 0, 1, 0, 0};
    tbl[7] = '{11, 0, 3, 6, 1, 1, 0, 3, 0};
    tbl[8] = '{12, 0, 1, 4, 0, 1, 0, 1, 1};
    tbl[9] = '{12, 0, 15, 18, 0, 1, 0, 15, 15};

    reset = 1'b1;
    instr_valid = 1'b0;
    mapped_address = '0;
    branch_taken = 1'b0;
    mem_ready = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    check("reset.strobes", {alu_en, mem_req, mem_we, rf_we, pc_inc, pc_load, illegal, mem_fault, halted}, 0);
    check("reset.retired", retired, 0);
    check("reset.upc", upc, 0);
    @(negedge clk);
    check("reset.ready_after_deassert", instr_ready, 1);

    for (int i = 0; i < 10; i++) begin
      do_instr(tbl[i].a, bit'(tbl[i].bt), tbl[i].rdy, t);
      exp_retired = (exp_retired + 1) % (1 << CNT_W);
      check("vec.latency", t.lat, tbl[i].lat);
      check("vec.rf_we", t.rfw, tbl[i].rfw);
      check("vec.pc_inc", t.inc, tbl[i].inc);
      check("vec.pc_load", t.ld, tbl[i].ld);
      check("vec.mem_req", t.mreq, tbl[i].mreq);
      check("vec.mem_we", t.mwe, tbl[i].mwe);
      check("vec.retired", retired, exp_retired);
      $display("vec %0d addr=%0d bt=%0d rdy=%0d lat=%0d retired=%0d",
               i, tbl[i].a, tbl[i].bt, tbl[i].rdy, t.lat, retired);
    end

    // Load with ready on the third MEM cycle: micro-PC walk
    run_and_check("load_upc", 11, 1'b0, 3);
    check("load_upc.c1", upc_log[1], 8'h2D);
    check("load_upc.c2", upc_log[2], 8'h2E);
    check("load_upc.c3", upc_log[3], 8'h2E);
    check("load_upc.c4", upc_log[4], 8'h2E);
    check("load_upc.c5", upc_log[5], 8'h2F);
    check("load_upc.c6", upc_log[6], 8'h2C);

    // Illegal entry address, then HALT stickiness against further requests
    run_and_check("illegal40", 40, 1'b0, 0);
    for (int i = 0; i < 4; i++) begin
      instr_valid = 1'b1;
      mapped_address = 6'd1;
      @(negedge clk);
      check("halt.halted", halted, 1);
      check("halt.ready", instr_ready, 0);
      check("halt.alu_en", alu_en, 0);
      check("halt.illegal", illegal, 1);
      check("halt.mem_fault", mem_fault, 0);
      check("halt.upc", upc, 8'hFC);
    end
    do_reset();

    // Store with no memory response: timeout trap
    run_and_check("store_timeout", 12, 1'b0, 0);
    for (int i = 0; i < 3; i++) begin
      instr_valid = 1'b1;
      mapped_address = 6'd1;
      @(negedge clk);
      check("fault.halted", halted, 1);
      check("fault.mem_fault", mem_fault, 1);
      check("fault.illegal", illegal, 0);
      check("fault.mem_req", mem_req, 0);
    end
    do_reset();

    // Reset pulsed while a load waits in MEM
    run_and_check("pre_rst_add", 1, 1'b0, 0);
    instr_valid = 1'b1;
    mapped_address = 6'd11;
    @(negedge clk);
    instr_valid = 1'b0;
    check("midrst.exec_alu", alu_en, 1);
    @(negedge clk);
    check("midrst.mem_req", mem_req, 1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    exp_retired = 0;
    check("midrst.strobes", {alu_en, mem_req, mem_we, rf_we, pc_inc, pc_load, illegal, mem_fault, halted}, 0);
    check("midrst.retired", retired, 0);
    check("midrst.upc", upc, 0);
    check("midrst.ready", instr_ready, 1);
    run_and_check("post_rst_add", 1, 1'b0, 0);

    // Retired counter wrap with a 4-bit counter
    do_reset();
    for (int i = 0; i < 17; i++) run_and_check("wrap_add", 2, 1'b0, 0);

    // Randomized instruction stream
    for (int i = 0; i < 200; i++) begin
      int a, r, sel;
      bit bt;
      sel = int'($urandom_range(0, 9));
      if (sel == 0) a = int'($urandom_range(27, 63));
      else if (sel < 4) a = int'($urandom_range(11, 12));
      else a = int'($urandom_range(0, 26));
      bt = 1'($urandom_range(0, 1));
      r = int'($urandom_range(1, 17));
      run_and_check("rand", a, bt, r);
      if (halted) do_reset();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
